// File: rtl/nebula_pkg.sv
// Shared types for the nebula core/cluster L2 path: requester ids, scheduler
// states, the latched request record and the round-robin ring step.
package nebula_pkg;

  typedef enum logic [1:0] {
    SRC_I    = 2'd0,
    SRC_D    = 2'd1,
    SRC_PTW  = 2'd2,
    SRC_NONE = 2'd3
  } l2_src_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } l2_sched_state_e;

  // Control half of a latched request; address and line data live in
  // width-parameterised registers in the scheduler itself.
  typedef struct packed {
    l2_src_e    src;
    logic       is_ifetch;
    logic       we;
    logic       is_amo;
    logic       upgrade;
    logic [4:0] amo_op;
  } l2_sched_req_t;

  // Ring order is I(0) -> D(1) -> PTW(2) -> I(0).
  function automatic logic [1:0] l2_rr_next(input logic [1:0] s);
    return (s >= 2'd2) ? 2'd0 : s + 2'd1;
  endfunction

endpackage

// File: rtl/nebula_rr_arb3.sv
// Three-way round-robin picker: searches the ring starting just after ptr.
// Purely combinational so the owner of ptr decides when it advances.
module nebula_rr_arb3
  import nebula_pkg::*;
(
  input  logic [2:0] req,
  input  logic [1:0] ptr,
  output logic       gnt_valid,
  output logic [1:0] gnt_id
);

  logic [1:0] c0, c1, c2;

  assign c0 = l2_rr_next(ptr);
  assign c1 = l2_rr_next(c0);
  assign c2 = l2_rr_next(c1);

  always_comb begin
    gnt_valid = |req;
    gnt_id    = SRC_NONE;
    if (req[c0])      gnt_id = c0;
    else if (req[c1]) gnt_id = c1;
    else if (req[c2]) gnt_id = c2;
  end

endmodule

// File: rtl/nebula_l2_req_sched.sv
// Per-core L2 request scheduler: round-robin over I$, D$ and PTW, one
// outstanding L2 transaction, owner-only response routing and WAIT timeout.
module nebula_l2_req_sched
  import nebula_pkg::*;
#(
  parameter int PADDR_WIDTH    = 56,
  parameter int LINE_SIZE      = 64,
  parameter int LINE_BITS      = LINE_SIZE * 8,
  parameter int XLEN           = 64,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                   clk,
  input  logic                   rst,

  input  logic                   i_req,
  input  logic [PADDR_WIDTH-1:0] i_addr,
  output logic                   i_ack,
  output logic [LINE_BITS-1:0]   i_rdata,
  output logic                   i_err,

  input  logic                   d_req,
  input  logic                   d_we,
  input  logic                   d_is_amo,
  input  logic                   d_upgrade,
  input  logic [4:0]             d_amo_op,
  input  logic [PADDR_WIDTH-1:0] d_addr,
  input  logic [LINE_BITS-1:0]   d_wdata,
  output logic                   d_ack,
  output logic [LINE_BITS-1:0]   d_rdata,
  output logic                   d_err,

  input  logic                   p_req,
  input  logic [PADDR_WIDTH-1:0] p_addr,
  output logic                   p_ack,
  output logic [XLEN-1:0]        p_rdata,
  output logic                   p_err,

  output logic                   l2_valid,
  input  logic                   l2_ready,
  output logic                   l2_is_ifetch,
  output logic                   l2_we,
  output logic                   l2_is_amo,
  output logic                   l2_upgrade,
  output logic [4:0]             l2_amo_op,
  output logic [PADDR_WIDTH-1:0] l2_addr,
  output logic [LINE_BITS-1:0]   l2_wdata,

  input  logic                   l2_resp_valid,
  input  logic [LINE_BITS-1:0]   l2_resp_rdata,
  input  logic                   l2_resp_err,

  output logic                   busy,
  output logic [1:0]             grant_id,
  output logic                   spurious_resp
);

  localparam int TW     = $clog2(TIMEOUT_CYCLES);
  localparam int WB     = $clog2(XLEN / 8);
  localparam int WSEL_W = $clog2(LINE_BITS / XLEN);

  l2_sched_state_e state_q, state_d;
  l2_sched_req_t   req_q;
  logic [1:0]      ptr_q;
  logic [TW-1:0]   timer_q;

  logic            arb_vld;
  logic [1:0]      arb_id;
  logic            timeout;
  logic            done;
  logic [LINE_BITS-1:0] resp_data;
  logic            resp_err;
  logic [WSEL_W-1:0] wsel;

  nebula_rr_arb3 u_arb (
    .req       ({p_req, d_req, i_req}),
    .ptr       (ptr_q),
    .gnt_valid (arb_vld),
    .gnt_id    (arb_id)
  );

  assign timeout   = (timer_q == TW'(TIMEOUT_CYCLES - 1));
  assign done      = l2_resp_valid || timeout;
  // A response landing on the timeout cycle still wins.
  assign resp_data = l2_resp_valid ? l2_resp_rdata : '0;
  assign resp_err  = l2_resp_valid ? l2_resp_err : 1'b1;
  assign wsel      = l2_addr[WB +: WSEL_W];

  assign l2_is_ifetch = req_q.is_ifetch;
  assign l2_we        = req_q.we;
  assign l2_is_amo    = req_q.is_amo;
  assign l2_upgrade   = req_q.upgrade;
  assign l2_amo_op    = req_q.amo_op;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (arb_vld)  state_d = ST_ISSUE;
      ST_ISSUE: if (l2_ready) state_d = ST_WAIT;
      ST_WAIT:  if (done)     state_d = ST_RESP;
      ST_RESP:                state_d = ST_IDLE;
      default:                state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_q         <= '{src: SRC_NONE, default: '0};
      ptr_q         <= SRC_I;
      timer_q       <= '0;
      l2_valid      <= 1'b0;
      l2_addr       <= '0;
      l2_wdata      <= '0;
      i_ack         <= 1'b0;
      i_err         <= 1'b0;
      i_rdata       <= '0;
      d_ack         <= 1'b0;
      d_err         <= 1'b0;
      d_rdata       <= '0;
      p_ack         <= 1'b0;
      p_err         <= 1'b0;
      p_rdata       <= '0;
      busy          <= 1'b0;
      grant_id      <= SRC_NONE;
      spurious_resp <= 1'b0;
    end else begin
      i_ack <= 1'b0;
      i_err <= 1'b0;
      d_ack <= 1'b0;
      d_err <= 1'b0;
      p_ack <= 1'b0;
      p_err <= 1'b0;
      busy  <= (state_d != ST_IDLE);
      // Anything arriving outside WAIT (incl. late post-timeout replies) is dropped.
      if (l2_resp_valid && state_q != ST_WAIT) spurious_resp <= 1'b1;

      case (state_q)
        ST_IDLE: begin
          if (arb_vld) begin
            l2_valid <= 1'b1;
            grant_id <= arb_id;
            case (arb_id)
              SRC_D: begin
                req_q    <= '{src: SRC_D, is_ifetch: 1'b0, we: d_we, is_amo: d_is_amo,
                              upgrade: d_upgrade, amo_op: d_amo_op};
                l2_addr  <= d_addr;
                l2_wdata <= d_wdata;
              end
              SRC_PTW: begin
                req_q    <= '{src: SRC_PTW, default: '0};
                l2_addr  <= p_addr;
                l2_wdata <= '0;
              end
              default: begin
                req_q    <= '{src: SRC_I, is_ifetch: 1'b1, default: '0};
                l2_addr  <= i_addr;
                l2_wdata <= '0;
              end
            endcase
          end
        end
        ST_ISSUE: begin
          if (l2_ready) begin
            l2_valid <= 1'b0;
            timer_q  <= '0;
          end
        end
        ST_WAIT: begin
          if (done) begin
            case (req_q.src)
              SRC_I: begin
                i_ack   <= 1'b1;
                i_err   <= resp_err;
                i_rdata <= resp_data;
              end
              SRC_D: begin
                d_ack   <= 1'b1;
                d_err   <= resp_err;
                d_rdata <= resp_data;
              end
              SRC_PTW: begin
                p_ack   <= 1'b1;
                p_err   <= resp_err;
                p_rdata <= resp_data[int'(wsel) * XLEN +: XLEN];
              end
              default: ;
            endcase
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        ST_RESP: begin
          ptr_q    <= req_q.src;
          grant_id <= SRC_NONE;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_nebula_l2_req_sched.sv
// Directed bench for nebula_l2_req_sched with TIMEOUT_CYCLES=8; inputs are
// driven and outputs sampled on the falling edge.
module tb_nebula_l2_req_sched;

  localparam int PW = 56;
  localparam int LB = 512;
  localparam int XL = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_req = 0, d_req = 0, p_req = 0;
  logic [PW-1:0] i_addr = '0, d_addr = '0, p_addr = '0;
  logic          d_we = 0, d_is_amo = 0, d_upgrade = 0;
  logic [4:0]    d_amo_op = '0;
  logic [LB-1:0] d_wdata = '0;
  logic          i_ack, i_err, d_ack, d_err, p_ack, p_err;
  logic [LB-1:0] i_rdata, d_rdata;
  logic [XL-1:0] p_rdata;
  logic          l2_valid, l2_ready = 0;
  logic          l2_is_ifetch, l2_we, l2_is_amo, l2_upgrade;
  logic [4:0]    l2_amo_op;
  logic [PW-1:0] l2_addr;
  logic [LB-1:0] l2_wdata;
  logic          l2_resp_valid = 0, l2_resp_err = 0;
  logic [LB-1:0] l2_resp_rdata = '0;
  logic          busy, spurious_resp;
  logic [1:0]    grant_id;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  nebula_l2_req_sched #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata), .i_err(i_err),
    .d_req(d_req), .d_we(d_we), .d_is_amo(d_is_amo), .d_upgrade(d_upgrade),
    .d_amo_op(d_amo_op), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
    .p_req(p_req), .p_addr(p_addr), .p_ack(p_ack), .p_rdata(p_rdata), .p_err(p_err),
    .l2_valid(l2_valid), .l2_ready(l2_ready), .l2_is_ifetch(l2_is_ifetch),
    .l2_we(l2_we), .l2_is_amo(l2_is_amo), .l2_upgrade(l2_upgrade),
    .l2_amo_op(l2_amo_op), .l2_addr(l2_addr), .l2_wdata(l2_wdata),
    .l2_resp_valid(l2_resp_valid), .l2_resp_rdata(l2_resp_rdata), .l2_resp_err(l2_resp_err),
    .busy(busy), .grant_id(grant_id), .spurious_resp(spurious_resp)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 20; n++) begin
      if (l2_valid) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL wait_valid: l2_valid=%b after 20 cycles, required 1", l2_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    total++;
    if ({i_ack, d_ack, p_ack, i_err, d_err, p_err, l2_valid, busy, spurious_resp} !== 9'b0) begin
      bad++;
      $display("FAIL reset_flags: got %b required 0", {i_ack, d_ack, p_ack, i_err, d_err, p_err, l2_valid, busy, spurious_resp});
    end
    total++;
    if (grant_id !== 2'd3) begin
      bad++;
      $display("FAIL reset_grant: got %0d required 3", grant_id);
    end
    total++;
    if (l2_addr !== '0 || i_rdata !== '0 || p_rdata !== '0 || l2_wdata !== '0) begin
      bad++;
      $display("FAIL reset_data: l2_addr=%h p_rdata=%h required 0", l2_addr, p_rdata);
    end
  endtask

  // All three requesting out of reset: expect D, PTW, I, D at 4-cycle spacing.
  task automatic test_back_to_back();
    int exp_src [4] = '{1, 2, 0, 1};
    logic [PW-1:0] exp_addr [3] = '{56'h100, 56'h200, 56'h308};
    logic [LB-1:0] line;
    logic [31:0]   w;
    int last_ack;
    bit ok;
    rst = 1'b1;
    i_addr = 56'h100; d_addr = 56'h200; p_addr = 56'h308;
    i_req = 1; d_req = 1; p_req = 1;
    l2_ready = 1;
    tick();
    rst = 1'b0;
    last_ack = 0;
    for (int k = 0; k < 4; k++) begin
      wait_valid(ok);
      total++;
      if (grant_id !== 2'(exp_src[k]) || l2_addr !== exp_addr[exp_src[k]]) begin
        bad++;
        $display("FAIL b2b_grant%0d: grant=%0d addr=%h required grant=%0d addr=%h",
                 k, grant_id, l2_addr, exp_src[k], exp_addr[exp_src[k]]);
      end
      total++;
      if (l2_is_ifetch !== (exp_src[k] == 0)) begin
        bad++;
        $display("FAIL b2b_ifetch%0d: got %b required %b", k, l2_is_ifetch, exp_src[k] == 0);
      end
      tick();
      w = 32'hA5A5_0000 + 32'(k);
      line = {16{w}};
      l2_resp_valid = 1; l2_resp_rdata = line; l2_resp_err = 0;
      tick();
      l2_resp_valid = 0;
      total++;
      if ({p_ack, d_ack, i_ack} !== (3'b001 << exp_src[k])) begin
        bad++;
        $display("FAIL b2b_ack%0d: acks(p,d,i)=%b required %b", k, {p_ack, d_ack, i_ack}, 3'b001 << exp_src[k]);
      end
      total++;
      if ((exp_src[k] == 0 && i_rdata !== line) || (exp_src[k] == 1 && d_rdata !== line) ||
          (exp_src[k] == 2 && p_rdata !== {w, w})) begin
        bad++;
        $display("FAIL b2b_data%0d: owner %0d data wrong, i=%h d=%h p=%h", k, exp_src[k],
                 i_rdata[63:0], d_rdata[63:0], p_rdata);
      end
      if (k > 0) begin
        total++;
        if (cyc - last_ack != 4) begin
          bad++;
          $display("FAIL b2b_spacing%0d: got %0d cycles required 4", k, cyc - last_ack);
        end
      end
      last_ack = cyc;
      if (k == 3) begin
        i_req = 0; d_req = 0; p_req = 0;
      end
      tick();
      total++;
      if ({p_ack, d_ack, i_ack} !== 3'b000) begin
        bad++;
        $display("FAIL b2b_stray%0d: acks(p,d,i)=%b required 000", k, {p_ack, d_ack, i_ack});
      end
    end
    tick();
  endtask

  task automatic test_ptw_word();
    logic [LB-1:0] line;
    bit ok;
    line = {8{64'h1111_2222_3333_4444}};
    line[5*64 +: 64] = 64'hDEAD_BEEF_0123_4567;
    p_addr = 56'h1234_5668;
    p_req = 1;
    wait_valid(ok);
    total++;
    if ({l2_we, l2_is_amo, l2_upgrade, l2_is_ifetch} !== 4'b0 || l2_amo_op !== 5'd0 || l2_wdata !== '0) begin
      bad++;
      $display("FAIL ptw_fields: we/amo/upg/if=%b amo_op=%0d required all 0", {l2_we, l2_is_amo, l2_upgrade, l2_is_ifetch}, l2_amo_op);
    end
    tick();
    l2_resp_valid = 1; l2_resp_rdata = line; l2_resp_err = 0;
    tick();
    l2_resp_valid = 0;
    total++;
    if (p_ack !== 1'b1 || p_err !== 1'b0 || i_ack !== 1'b0 || d_ack !== 1'b0) begin
      bad++;
      $display("FAIL ptw_ack: p_ack=%b p_err=%b i_ack=%b d_ack=%b required 1 0 0 0", p_ack, p_err, i_ack, d_ack);
    end
    total++;
    if (p_rdata !== 64'hDEAD_BEEF_0123_4567) begin
      bad++;
      $display("FAIL ptw_word: got %h required deadbeef01234567", p_rdata);
    end
    p_req = 0;
    tick();
    total++;
    if (p_ack !== 1'b0 || p_rdata !== 64'hDEAD_BEEF_0123_4567) begin
      bad++;
      $display("FAIL ptw_hold: p_ack=%b p_rdata=%h required 0 deadbeef01234567", p_ack, p_rdata);
    end
    tick();
  endtask

  task automatic test_issue_stall();
    logic [LB-1:0] wd;
    logic [LB-1:0] line;
    bit ok;
    wd = {8{64'hCAFE_F00D_0000_0042}};
    line = {8{64'h7777_0000_8888_0001}};
    l2_ready = 0;
    d_addr = 56'h00AB_CDC0; d_we = 1; d_is_amo = 1; d_upgrade = 1; d_amo_op = 5'd13; d_wdata = wd;
    d_req = 1;
    wait_valid(ok);
    for (int c = 0; c < 7; c++) begin
      if (c == 2) d_addr = 56'h0000_0040;
      total++;
      if (l2_valid !== 1'b1 || l2_addr !== 56'h00AB_CDC0 || l2_wdata !== wd ||
          {l2_we, l2_is_amo, l2_upgrade, l2_is_ifetch} !== 4'b1110 || l2_amo_op !== 5'd13) begin
        bad++;
        $display("FAIL stall_hold%0d: valid=%b addr=%h ctl=%b op=%0d required 1 abcdc0 1110 13",
                 c, l2_valid, l2_addr, {l2_we, l2_is_amo, l2_upgrade, l2_is_ifetch}, l2_amo_op);
      end
      tick();
    end
    l2_ready = 1;
    total++;
    if (l2_valid !== 1'b1) begin
      bad++;
      $display("FAIL stall_ready_cycle: l2_valid=%b required 1", l2_valid);
    end
    tick();
    total++;
    if (l2_valid !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL stall_wait: l2_valid=%b busy=%b required 0 1", l2_valid, busy);
    end
    l2_resp_valid = 1; l2_resp_rdata = line; l2_resp_err = 1;
    tick();
    l2_resp_valid = 0; l2_resp_err = 0;
    total++;
    if (d_ack !== 1'b1 || d_err !== 1'b1 || d_rdata !== line) begin
      bad++;
      $display("FAIL stall_resp: d_ack=%b d_err=%b d_rdata=%h required 1 1 line", d_ack, d_err, d_rdata[63:0]);
    end
    d_req = 0; d_we = 0; d_is_amo = 0; d_upgrade = 0; d_amo_op = '0;
    tick();
    tick();
  endtask

  task automatic test_timeout();
    bit ok;
    i_addr = 56'h0000_0F00;
    i_req = 1;
    l2_ready = 1;
    wait_valid(ok);
    for (int j = 1; j <= 9; j++) begin
      tick();
      if (j < 9) begin
        total++;
        if (i_ack !== 1'b0) begin
          bad++;
          $display("FAIL timeout_early: i_ack=1 at %0d cycles after handshake, required 9", j);
        end
      end
    end
    total++;
    if (i_ack !== 1'b1 || i_err !== 1'b1 || i_rdata !== '0) begin
      bad++;
      $display("FAIL timeout_ack: i_ack=%b i_err=%b i_rdata=%h required 1 1 0", i_ack, i_err, i_rdata[63:0]);
    end
    i_req = 0;
    tick();
    total++;
    if (spurious_resp !== 1'b0) begin
      bad++;
      $display("FAIL spurious_pre: got %b required 0", spurious_resp);
    end
    l2_resp_valid = 1; l2_resp_rdata = {16{32'h5A5A_5A5A}};
    tick();
    l2_resp_valid = 0;
    tick();
    total++;
    if (spurious_resp !== 1'b1 || {i_ack, d_ack, p_ack} !== 3'b000 || busy !== 1'b0) begin
      bad++;
      $display("FAIL spurious_late: spurious=%b acks=%b busy=%b required 1 000 0", spurious_resp, {i_ack, d_ack, p_ack}, busy);
    end
  endtask

  task automatic test_resp_at_limit();
    logic [LB-1:0] line;
    bit ok;
    line = {8{64'h0BAD_C0DE_0000_1234}};
    d_addr = 56'h0000_1000;
    d_req = 1;
    wait_valid(ok);
    for (int j = 1; j <= 8; j++) tick();
    total++;
    if (d_ack !== 1'b0) begin
      bad++;
      $display("FAIL limit_early: d_ack=%b required 0", d_ack);
    end
    l2_resp_valid = 1; l2_resp_rdata = line; l2_resp_err = 0;
    tick();
    l2_resp_valid = 0;
    total++;
    if (d_ack !== 1'b1 || d_err !== 1'b0 || d_rdata !== line) begin
      bad++;
      $display("FAIL limit_resp: d_ack=%b d_err=%b d_rdata=%h required 1 0 0badc0de00001234",
               d_ack, d_err, d_rdata[63:0]);
    end
    d_req = 0;
    tick();
    tick();
  endtask

  task automatic test_reset_mid();
    bit ok;
    p_addr = 56'h0000_2000;
    p_req = 1;
    wait_valid(ok);
    tick();
    rst = 1'b1;
    p_req = 0;
    tick();
    total++;
    if (grant_id !== 2'd3 || busy !== 1'b0 || l2_valid !== 1'b0 || spurious_resp !== 1'b0) begin
      bad++;
      $display("FAIL rstmid_ctl: grant=%0d busy=%b valid=%b spurious=%b required 3 0 0 0",
               grant_id, busy, l2_valid, spurious_resp);
    end
    total++;
    if (p_rdata !== '0 || d_rdata !== '0 || l2_addr !== '0) begin
      bad++;
      $display("FAIL rstmid_data: p_rdata=%h l2_addr=%h required 0", p_rdata, l2_addr);
    end
    rst = 1'b0;
    for (int j = 0; j < 10; j++) begin
      tick();
      total++;
      if ({i_ack, d_ack, p_ack} !== 3'b000 || busy !== 1'b0) begin
        bad++;
        $display("FAIL rstmid_quiet%0d: acks=%b busy=%b required 000 0", j, {i_ack, d_ack, p_ack}, busy);
      end
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_ptw_word();
    test_issue_stall();
    test_timeout();
    test_resp_at_limit();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
